// File: rtl/adc_scan_sequencer_if.sv
// Bundle of register-side controls, ADC front-end handshake and filter-bank strobe
// seen by the ADC scan sequencer.
interface adc_scan_sequencer_if #(
    parameter int unsigned NUM_CH = 8,
    parameter int unsigned CH_W   = 3,
    parameter int unsigned DATA_W = 16
) ();
    logic              enable;
    logic [NUM_CH-1:0] ch_mask;
    logic              err_clr;
    logic              adc_start;
    logic [CH_W-1:0]   adc_ch;
    logic              adc_done;
    logic [DATA_W-1:0] adc_data;
    logic              filt_next;
    logic [CH_W-1:0]   filt_ch;
    logic [DATA_W-1:0] filt_data;
    logic              scan_done;
    logic              busy;
    logic              overrun_err;
    logic              timeout_err;

    modport master (
        input  enable, ch_mask, err_clr, adc_done, adc_data,
        output adc_start, adc_ch, filt_next, filt_ch, filt_data,
               scan_done, busy, overrun_err, timeout_err
    );

    modport slave (
        output enable, ch_mask, err_clr, adc_done, adc_data,
        input  adc_start, adc_ch, filt_next, filt_ch, filt_data,
               scan_done, busy, overrun_err, timeout_err
    );
endinterface

// File: rtl/adc_scan_sequencer.sv
// Periodic multi-channel ADC scan controller: walks enabled channels once per tick,
// handshakes each conversion with timeout and forwards samples to the filter bank.
module adc_scan_sequencer #(
    parameter int unsigned NUM_CH  = 8,
    parameter int unsigned CH_W    = 3,
    parameter int unsigned PERIOD  = 48000,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned DATA_W  = 16
) (
    input logic                  clk48mhz,
    input logic                  rstn,
    adc_scan_sequencer_if.master bus
);
    localparam int unsigned CNT_W = $clog2(PERIOD);
    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_CONVERT,
        S_STORE,
        S_ADVANCE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [TO_W-1:0]   r_tcnt;
    logic [NUM_CH-1:0] r_mask;
    logic [CH_W-1:0]   r_ch;
    logic              r_adc_start;
    logic              r_filt_next;
    logic [CH_W-1:0]   r_filt_ch;
    logic [DATA_W-1:0] r_filt_data;
    logic              r_scan_done;
    logic              r_busy;
    logic              r_overrun_err;
    logic              r_timeout_err;
    logic              w_tick;
    logic              w_tout;
    logic [CH_W:0]     w_first;
    logic [CH_W:0]     w_next;

    // Lowest set bit of mask at index >= lo, returned as {valid, index}.
    function automatic logic [CH_W:0] f_pick(input logic [NUM_CH-1:0] mask, input int lo);
        logic [CH_W:0] res;
        res = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (mask[CH_W'(i)] && (i >= lo)) res = {1'b1, CH_W'(i)};
        end
        return res;
    endfunction

    assign w_tick  = bus.enable && (r_cnt == CNT_W'(PERIOD - 1));
    assign w_tout  = (r_tcnt == TO_W'(TIMEOUT - 1));
    assign w_first = f_pick(bus.ch_mask, 0);
    assign w_next  = f_pick(r_mask, int'(r_ch) + 1);

    always_ff @(posedge clk48mhz or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_tick && w_first[CH_W]) w_state_nxt = S_START;
            S_START:   w_state_nxt = S_CONVERT;
            S_CONVERT: begin
                if (bus.adc_done)  w_state_nxt = S_STORE;
                else if (w_tout)   w_state_nxt = S_ADVANCE;
            end
            S_STORE:   w_state_nxt = S_ADVANCE;
            S_ADVANCE: w_state_nxt = w_next[CH_W] ? S_START : S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Tick counter is held at zero while disabled so a re-enable waits a full period.
    always_ff @(posedge clk48mhz or negedge rstn) begin
        if (!rstn)             r_cnt <= '0;
        else if (!bus.enable)  r_cnt <= '0;
        else if (w_tick)       r_cnt <= '0;
        else                   r_cnt <= r_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk48mhz or negedge rstn) begin
        if (!rstn) begin
            r_mask <= '0;
            r_ch   <= '0;
            r_tcnt <= '0;
        end else begin
            if (r_state == S_IDLE && w_state_nxt == S_START) begin
                r_mask <= bus.ch_mask;
                r_ch   <= w_first[CH_W-1:0];
            end else if (r_state == S_ADVANCE && w_next[CH_W]) begin
                r_ch   <= w_next[CH_W-1:0];
            end
            if (r_state == S_START)        r_tcnt <= '0;
            else if (r_state == S_CONVERT) r_tcnt <= r_tcnt + TO_W'(1);
        end
    end

    // Strobes follow the state being entered so they line up with that state's cycle.
    always_ff @(posedge clk48mhz or negedge rstn) begin
        if (!rstn) begin
            r_adc_start <= 1'b0;
            r_filt_next <= 1'b0;
            r_filt_ch   <= '0;
            r_filt_data <= '0;
            r_scan_done <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_adc_start <= (w_state_nxt == S_START);
            r_filt_next <= (w_state_nxt == S_STORE);
            r_scan_done <= (w_state_nxt == S_ADVANCE) && !w_next[CH_W];
            r_busy      <= (w_state_nxt != S_IDLE);
            if (w_state_nxt == S_STORE) begin
                r_filt_ch   <= r_ch;
                r_filt_data <= bus.adc_data;
            end
        end
    end

    // Sticky flags; a set event wins over a simultaneous clear.
    always_ff @(posedge clk48mhz or negedge rstn) begin
        if (!rstn) begin
            r_overrun_err <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_tick && r_state != S_IDLE) r_overrun_err <= 1'b1;
            else if (bus.err_clr)            r_overrun_err <= 1'b0;
            if (r_state == S_CONVERT && !bus.adc_done && w_tout) r_timeout_err <= 1'b1;
            else if (bus.err_clr)                                 r_timeout_err <= 1'b0;
        end
    end

    assign bus.adc_start   = r_adc_start;
    assign bus.adc_ch      = r_ch;
    assign bus.filt_next   = r_filt_next;
    assign bus.filt_ch     = r_filt_ch;
    assign bus.filt_data   = r_filt_data;
    assign bus.scan_done   = r_scan_done;
    assign bus.busy        = r_busy;
    assign bus.overrun_err = r_overrun_err;
    assign bus.timeout_err = r_timeout_err;
endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Randomized bench for adc_scan_sequencer: each scan is planned as a timeline of
// expected events per cycle, and the bench plays the ADC front end from that plan.
module tb_adc_scan_sequencer;
    localparam int NCH  = 8;
    localparam int CHW  = 3;
    localparam int DW   = 16;
    localparam int P    = 16;
    localparam int TO   = 255;
    localparam int MAXC = 8000;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    adc_scan_sequencer_if #(.NUM_CH(NCH), .CH_W(CHW), .DATA_W(DW)) bus ();

    adc_scan_sequencer #(
        .NUM_CH(NCH), .CH_W(CHW), .PERIOD(P), .TIMEOUT(TO), .DATA_W(DW)
    ) dut (
        .clk48mhz(clk),
        .rstn    (rstn),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    // Per-cycle expectations, filled when a scan is planned at its tick.
    int          exp_start [MAXC];
    int          exp_filt  [MAXC];
    logic [15:0] exp_fdata [MAXC];
    bit          exp_sdone [MAXC];
    bit          exp_busy  [MAXC];
    bit          set_to    [MAXC];
    bit          done_v    [MAXC];
    logic [15:0] done_d    [MAXC];

    int          cyc, m_run, m_ach, m_fch, m_scan_T;
    logic [7:0]  m_scan_mask;
    logic [15:0] m_fdata;
    bit          m_ov, m_to;
    int          cnt_fn, cnt_sd;

    bit          g_en, g_clr, g_spur;
    logic [7:0]  g_mask;
    int          g_mode, g_delay;
    logic [15:0] data_tbl [NCH];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < MAXC; c++) begin
            exp_start[c] = -1; exp_filt[c] = -1; exp_fdata[c] = '0;
            exp_sdone[c] = 0;  exp_busy[c] = 0;  set_to[c] = 0;
            done_v[c] = 0;     done_d[c] = '0;
        end
        cyc = 0; m_run = 0; m_ach = 0; m_fch = 0; m_fdata = '0;
        m_ov = 0; m_to = 0; m_scan_T = -1; m_scan_mask = '0;
    endtask

    // Lay out the whole scan: channels ascending, each start->done->filt->advance.
    task automatic plan_scan(input int t0, input logic [7:0] mask);
        int t;
        int adv;
        t = t0 + 1;
        adv = t0 + 1;
        m_scan_T = t0;
        m_scan_mask = mask;
        for (int ch = 0; ch < NCH; ch++) begin
            if (mask[ch]) begin
                bit tmo;
                int d;
                logic [15:0] dat;
                tmo = 0; d = 1; dat = '0;
                case (g_mode)
                    0: begin tmo = ($urandom_range(0, 15) == 0); d = $urandom_range(1, 12); dat = 16'($urandom); end
                    1: begin d = g_delay; dat = data_tbl[ch]; end
                    default: tmo = 1;
                endcase
                exp_start[t] = ch;
                if (tmo) begin
                    set_to[t + TO] = 1;
                    adv = t + TO + 1;
                end else begin
                    done_v[t + d] = 1;
                    done_d[t + d] = dat;
                    exp_filt[t + d + 1] = ch;
                    exp_fdata[t + d + 1] = dat;
                    adv = t + d + 2;
                end
                t = adv + 1;
            end
        end
        exp_sdone[adv] = 1;
        for (int c = t0 + 1; c <= adv; c++) exp_busy[c] = 1;
    endtask

    task automatic step();
        bit tick, ovset;
        if (cyc >= MAXC - 2200) begin
            $display("FAIL cycle_budget cyc=%0d got=%0d exp<%0d", cyc, cyc, MAXC - 2200);
            $fatal(1);
        end
        if (exp_start[cyc] >= 0) m_ach = exp_start[cyc];
        if (exp_filt[cyc] >= 0) begin m_fch = exp_filt[cyc]; m_fdata = exp_fdata[cyc]; end
        chk("adc_start",   32'(bus.adc_start),   32'(exp_start[cyc] >= 0));
        chk("adc_ch",      32'(bus.adc_ch),      32'(m_ach));
        chk("filt_next",   32'(bus.filt_next),   32'(exp_filt[cyc] >= 0));
        chk("filt_ch",     32'(bus.filt_ch),     32'(m_fch));
        chk("filt_data",   32'(bus.filt_data),   32'(m_fdata));
        chk("scan_done",   32'(bus.scan_done),   32'(exp_sdone[cyc]));
        chk("busy",        32'(bus.busy),        32'(exp_busy[cyc]));
        chk("overrun_err", 32'(bus.overrun_err), 32'(m_ov));
        chk("timeout_err", 32'(bus.timeout_err), 32'(m_to));
        if (bus.filt_next === 1'b1) cnt_fn++;
        if (bus.scan_done === 1'b1) cnt_sd++;

        bus.enable  = g_en;
        bus.ch_mask = g_mask;
        bus.err_clr = g_clr;
        if (done_v[cyc]) begin
            bus.adc_done = 1'b1;
            bus.adc_data = done_d[cyc];
        end else begin
            bus.adc_done = g_spur && !exp_busy[cyc] && ($urandom_range(0, 7) == 0);
            bus.adc_data = 16'($urandom);
        end

        tick  = g_en && ((m_run % P) == P - 1);
        ovset = 0;
        if (tick) begin
            if (exp_busy[cyc])   ovset = 1;
            else if (g_mask != 0) plan_scan(cyc, g_mask);
        end
        m_ov  = ovset ? 1'b1 : (g_clr ? 1'b0 : m_ov);
        m_to  = set_to[cyc] ? 1'b1 : (g_clr ? 1'b0 : m_to);
        m_run = g_en ? m_run + 1 : 0;
        g_clr = 0;
        cyc++;
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rstn = 1'b0;
        bus.enable = 0; bus.ch_mask = '0; bus.err_clr = 0; bus.adc_done = 0; bus.adc_data = '0;
        repeat (3) @(negedge clk);
        model_clear();
        rstn = 1'b1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_adc_start"}, 32'(bus.adc_start),   0);
        chk({tag, "_adc_ch"},    32'(bus.adc_ch),      0);
        chk({tag, "_filt_next"}, 32'(bus.filt_next),   0);
        chk({tag, "_filt_ch"},   32'(bus.filt_ch),     0);
        chk({tag, "_filt_data"}, 32'(bus.filt_data),   0);
        chk({tag, "_scan_done"}, 32'(bus.scan_done),   0);
        chk({tag, "_busy"},      32'(bus.busy),        0);
        chk({tag, "_overrun"},   32'(bus.overrun_err), 0);
        chk({tag, "_timeout"},   32'(bus.timeout_err), 0);
    endtask

    initial begin
        int fn0, sd0, t_mark;
        bit found;
        g_en = 0; g_clr = 0; g_spur = 0; g_mask = '0; g_mode = 1; g_delay = 3;
        for (int i = 0; i < NCH; i++) data_tbl[i] = 16'($urandom);
        data_tbl[0] = 16'h1234;
        data_tbl[2] = 16'hABCD;
        reset_dut();
        chk_zero("reset");

        // Two-channel scan, fixed 3-cycle conversions.
        g_en = 1; g_mask = 8'h05; g_mode = 1; g_delay = 3;
        fn0 = cnt_fn; sd0 = cnt_sd;
        repeat (64) step();
        chk("A_filt_count",  32'(cnt_fn - fn0), 32'd6);
        chk("A_sdone_count", 32'(cnt_sd - sd0), 32'd3);

        // Channel 7 never answers.
        g_mask = 8'h80; g_mode = 2;
        repeat (600) step();

        // Four slow channels overrun the period; clear and re-set the flag.
        g_clr = 1; step();
        g_mask = 8'h0F; g_mode = 1; g_delay = 10;
        repeat (120) step();
        g_clr = 1; step();
        repeat (120) step();

        // Empty mask discards ticks, then a single channel resumes.
        g_mask = 8'h00;
        repeat (3 * P) step();
        g_mask = 8'h01; g_delay = 4;
        repeat (40) step();

        // Drop enable during channel 1 conversion.
        g_mask = 8'h03; g_delay = 5;
        t_mark = cyc; found = 0;
        for (int k = 0; k < 300 && !found; k++) begin
            step();
            found = (m_scan_mask == 8'h03) && (m_scan_T >= t_mark);
        end
        chk("E_scan_seen", 32'(found), 32'd1);
        if (found) begin
            while (cyc < m_scan_T + 11) step();
            g_en = 0;
            repeat (60) step();
            g_en = 1;
            repeat (40) step();
        end

        // Random mix of masks, enables, clears and stray adc_done pulses.
        g_mode = 0; g_spur = 1;
        for (int k = 0; k < 1500; k++) begin
            if (g_en && $urandom_range(0, 99) == 0) g_en = 0;
            else if (!g_en && $urandom_range(0, 9) == 0) g_en = 1;
            if ($urandom_range(0, 19) == 0) g_mask = 8'($urandom);
            if ($urandom_range(0, 9) == 0) g_clr = 1;
            step();
        end

        // Reset in the middle of a conversion, then a late adc_done.
        g_spur = 0; g_en = 0;
        for (int k = 0; k < 2500 && exp_busy[cyc]; k++) step();
        chk("G_idle", 32'(exp_busy[cyc]), 32'd0);
        g_en = 1; g_mask = 8'h01; g_mode = 1; g_delay = 40;
        t_mark = cyc; found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            step();
            found = (m_scan_T >= t_mark);
        end
        chk("G_scan_seen", 32'(found), 32'd1);
        while (found && cyc < m_scan_T + 5) step();
        chk("G_busy_pre", 32'(bus.busy), 32'd1);
        rstn = 1'b0; bus.enable = 0; bus.adc_done = 0;
        #1;
        chk_zero("G_async");
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        bus.adc_done = 1'b1; bus.adc_data = 16'hBEEF;
        @(negedge clk);
        bus.adc_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk_zero("G_late");
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
